hs_rr_arb: RTL

Round-robin arbiter that shares one valid/ready pipeline between NUM upstream requesters. Each requester presents beats with a packet-end marker. A grant is held from the first accepted beat of a packet until its last beat is accepted. The granted stream is forwarded through a single registered output stage that drives the shared downstream handshake pipeline.

---
 rtl/hs_rr_arb.sv | 104 ++++++++++
 1 files changed

// File: rtl/hs_rr_arb.sv
`default_nettype none
// ============================================================================
// Module      : hs_rr_arb
// Description : Packet-locked round-robin arbiter. It shares one registered
//               valid/ready output stage among NUM requesters.
// Revision    : 1.0 - initial release
// ============================================================================
module hs_rr_arb #(
  parameter int WIDTH = 8,
  parameter int NUM   = 4,
  localparam int SELW = $clog2(NUM)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM-1:0]       i_valid,
  input  logic [NUM*WIDTH-1:0] i_data,
  input  logic [NUM-1:0]       i_last,
  output logic [NUM-1:0]       o_ready,
  input  logic                 i_ready,
  output logic                 o_valid,
  output logic [WIDTH-1:0]     o_data,
  output logic                 o_last,
  output logic [SELW-1:0]      o_sel
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [SELW-1:0] r_ptr;
  logic [SELW-1:0] r_grant;
  logic [SELW-1:0] w_pick;
  logic [SELW-1:0] w_grant;
  logic [SELW-1:0] w_ptr_nxt;
  logic            w_found;
  logic            w_grant_ok;
  logic            w_out_en;
  logic            w_xfer;
  logic            w_last;
  logic [WIDTH-1:0] w_data;
  int              w_idx;

  // First requesting index at or after r_ptr, wrapping modulo NUM.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_idx   = 0;
    for (int i = 0; i < NUM; i++) begin
      w_idx = (int'(r_ptr) + i) % NUM;
      if (!w_found && i_valid[w_idx]) begin
        w_found = 1'b1;
        w_pick  = SELW'(w_idx);
      end
    end
  end

  assign w_out_en   = i_ready | ~o_valid;
  assign w_grant    = (r_state == ST_LOCKED) ? r_grant : w_pick;
  assign w_grant_ok = (r_state == ST_LOCKED) ? 1'b1 : w_found;
  assign o_ready    = (w_out_en && w_grant_ok) ? ({{(NUM-1){1'b0}}, 1'b1} << w_grant) : '0;
  assign w_xfer     = |(o_ready & i_valid);
  assign w_last     = i_last[w_grant];
  assign w_data     = i_data[int'(w_grant)*WIDTH +: WIDTH];
  assign w_ptr_nxt  = (int'(w_grant) == NUM-1) ? '0 : w_grant + 1'b1;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_xfer && !w_last) w_state_nxt = ST_LOCKED;
      ST_LOCKED: if (w_xfer && w_last)  w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_grant <= '0;
      o_valid <= 1'b0;
      o_last  <= 1'b0;
      o_sel   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_xfer) r_grant <= w_grant;
      if (w_xfer && w_last) r_ptr <= w_ptr_nxt;
      if (w_out_en) o_valid <= w_xfer;
      if (w_xfer) begin
        o_last <= w_last;
        o_sel  <= w_grant;
      end
    end
  end

  // Data path carries no reset; o_valid qualifies it.
  always_ff @(posedge clk) begin
    if (w_xfer) o_data <= w_data;
  end

endmodule
`default_nettype wire
